// File: rtl/mem_arbiter.sv
// Two-master arbiter for shared data/pixel memories.
// CPU single beats vs pixel-engine bursts, with starvation guard.
module mem_arbiter #(
  parameter int N      = 32,
  parameter int STARVE = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic         a_we,
  input  logic         a_sel,
  input  logic [N-1:0] a_addr,
  input  logic [N-1:0] a_wdata,
  output logic         a_stall,
  output logic         a_rvalid,
  output logic [N-1:0] a_rdata,
  input  logic         b_req,
  input  logic         b_we,
  input  logic         b_sel,
  input  logic [N-1:0] b_addr,
  input  logic [3:0]   b_len,
  input  logic [N-1:0] b_wdata,
  output logic         b_gnt,
  output logic         b_rvalid,
  output logic [N-1:0] b_rdata,
  output logic         b_done,
  output logic         dm_we,
  output logic         pm_we,
  output logic [N-1:0] m_addr,
  output logic [N-1:0] m_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic [N-1:0] pm_rdata
);

  localparam int SW = $clog2(STARVE + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         r_state;
  logic [SW-1:0]  r_starve;
  logic [N-1:0]   r_addr;
  logic [3:0]     r_left;
  logic           r_we;
  logic           r_sel;
  logic           r_a_rv;
  logic           r_b_rv;
  logic           r_rsel;

  logic           w_starved;
  logic           w_a_go;
  logic           w_b_go;
  logic           w_b_new;
  logic           w_last;
  logic           w_we;
  logic           w_sel;
  logic [N-1:0]   w_addr;
  logic [N-1:0]   w_wdata;
  logic [N-1:0]   w_rd;

  assign w_starved = (r_starve == SW'(STARVE));

  // Issue decision; gated by rst so reset silences all strobes at once
  always_comb begin
    w_a_go  = 1'b0;
    w_b_go  = 1'b0;
    w_b_new = 1'b0;
    w_last  = 1'b0;
    w_we    = 1'b0;
    w_sel   = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (rst) begin
      if (r_state == BURST) begin
        w_b_go  = 1'b1;
        w_last  = (r_left == 4'd1);
        w_we    = r_we;
        w_sel   = r_sel;
        w_addr  = r_addr;
        w_wdata = b_wdata;
      end else if (b_req && (!a_req || w_starved)) begin
        w_b_go  = 1'b1;
        w_b_new = 1'b1;
        w_last  = (b_len == 4'd0);
        w_we    = b_we;
        w_sel   = b_sel;
        w_addr  = b_addr;
        w_wdata = b_wdata;
      end else if (a_req) begin
        w_a_go  = 1'b1;
        w_we    = a_we;
        w_sel   = a_sel;
        w_addr  = a_addr;
        w_wdata = a_wdata;
      end
    end
  end

  assign a_stall = rst & a_req & ~w_a_go;
  assign b_gnt   = w_b_go;
  assign b_done  = w_b_go & w_last;
  assign dm_we   = w_we & ~w_sel;
  assign pm_we   = w_we & w_sel;
  assign m_addr  = w_addr;
  assign m_wdata = w_wdata;

  assign w_rd     = r_rsel ? pm_rdata : dm_rdata;
  assign a_rvalid = r_a_rv;
  assign b_rvalid = r_b_rv;
  assign a_rdata  = r_a_rv ? w_rd : '0;
  assign b_rdata  = r_b_rv ? w_rd : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_addr   <= '0;
      r_left   <= '0;
      r_we     <= 1'b0;
      r_sel    <= 1'b0;
      r_a_rv   <= 1'b0;
      r_b_rv   <= 1'b0;
      r_rsel   <= 1'b0;
    end else begin
      r_a_rv <= w_a_go & ~w_we;
      r_b_rv <= w_b_go & ~w_we;
      r_rsel <= w_sel;
      if (w_b_go || !b_req)
        r_starve <= '0;
      else if (!w_starved)
        r_starve <= r_starve + SW'(1);
      if (w_b_go)
        r_addr <= w_addr + N'(4);
      unique case (r_state)
        IDLE: begin
          if (w_b_new && b_len != 4'd0) begin
            r_state <= BURST;
            r_left  <= b_len;
            r_we    <= b_we;
            r_sel   <= b_sel;
          end
        end
        BURST: begin
          r_left <= r_left - 4'd1;
          if (w_last)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic
// checked against a queue-based reference model.
module tb_mem_arbiter;

  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req, a_we, a_sel;
  logic [31:0] a_addr, a_wdata;
  logic        a_stall, a_rvalid;
  logic [31:0] a_rdata;
  logic        b_req, b_we, b_sel;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_len;
  logic        b_gnt, b_rvalid, b_done;
  logic [31:0] b_rdata;
  logic        dm_we, pm_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] dm_rdata, pm_rdata;

  mem_arbiter #(.N(32), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_sel(a_sel),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_sel(b_sel),
    .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_done(b_done),
    .dm_we(dm_we), .pm_we(pm_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .dm_rdata(dm_rdata), .pm_rdata(pm_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining beat addresses of the open burst,
  // B's wait count, and the owner of the read in flight.
  logic [31:0] q_addr[$];
  logic        q_we, q_sel;
  int          wait_c = 0;
  int          pend = 0;
  logic        pend_sel = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    a_req = 0; a_we = 0; a_sel = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_sel = 0; b_addr = 0; b_len = 0;
    b_wdata = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    dm_rdata = $urandom;
    pm_rdata = $urandom;
  endtask

  task automatic tick();
    int          who;
    logic        we, sel, done, e_arv, e_brv, e_stall;
    logic [31:0] ad, wd, rd;
    #2;
    if (!rst) begin
      q_addr.delete();
      wait_c = 0;
      pend = 0;
    end
    e_arv = (pend == 1);
    e_brv = (pend == 2);
    rd = pend_sel ? pm_rdata : dm_rdata;
    who = 0; we = 0; sel = 0; done = 0; ad = 0; wd = 0;
    if (rst) begin
      if (q_addr.size() > 0) begin
        who = 2; ad = q_addr.pop_front();
        we = q_we; sel = q_sel; wd = b_wdata;
        done = (q_addr.size() == 0);
      end else if (b_req && (!a_req || wait_c == STARVE)) begin
        who = 2; ad = b_addr; we = b_we; sel = b_sel; wd = b_wdata;
        q_we = b_we; q_sel = b_sel;
        for (int k = 1; k <= int'(b_len); k++)
          q_addr.push_back(b_addr + 32'(4 * k));
        done = (b_len == 0);
      end else if (a_req) begin
        who = 1; ad = a_addr; we = a_we; sel = a_sel; wd = a_wdata;
      end
    end
    e_stall = rst && a_req && who != 1;
    chk("flags{stall,gnt,done,dmwe,pmwe,arv,brv}",
        {25'b0, a_stall, b_gnt, b_done, dm_we, pm_we, a_rvalid, b_rvalid},
        {25'b0, e_stall, who == 2, done, we && !sel, we && sel,
         e_arv, e_brv});
    chk("m_addr", m_addr, ad);
    chk("m_wdata", m_wdata, wd);
    chk("a_rdata", a_rdata, e_arv ? rd : 32'h0);
    chk("b_rdata", b_rdata, e_brv ? rd : 32'h0);
    if (rst) begin
      pend = (who != 0 && !we) ? who : 0;
      pend_sel = sel;
      if (who == 2 || !b_req) wait_c = 0;
      else if (wait_c < STARVE) wait_c++;
    end
  endtask

  initial begin
    clr_in();
    dm_rdata = 0; pm_rdata = 0;
    rst = 0;
    nxt(); nxt(); tick();
    chk("reset_stall", 32'(a_stall), 32'h0);
    nxt(); rst = 1; tick();

    // CPU read of data memory
    nxt(); clr_in(); a_req = 1; a_addr = 32'h10; tick();
    chk("cpu_rd_addr", m_addr, 32'h10);
    chk("cpu_rd_stall", 32'(a_stall), 32'h0);
    nxt(); clr_in(); dm_rdata = 32'hCAFE; tick();
    chk("cpu_rd_rvalid", 32'(a_rvalid), 32'h1);
    chk("cpu_rd_data", a_rdata, 32'hCAFE);

    // Pixel write burst, CPU blocked from beat 2, inputs jittered
    nxt(); clr_in();
    b_req = 1; b_we = 1; b_sel = 1; b_addr = 32'h100; b_len = 3;
    b_wdata = $urandom; tick();
    chk("pw_beat0_addr", m_addr, 32'h100);
    chk("pw_beat0_pmwe", 32'(pm_we), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      nxt();
      a_req = 1; b_addr = $urandom; b_len = 4'($urandom);
      b_sel = 0; b_wdata = $urandom;
      tick();
      chk("pw_beat_addr", m_addr, 32'h100 + 32'(4 * i));
      chk("pw_beat_stall", 32'(a_stall), 32'h1);
      chk("pw_beat_done", 32'(b_done), 32'(i == 3));
    end
    nxt(); clr_in(); a_req = 1; tick();
    chk("pw_after_stall", 32'(a_stall), 32'h0);

    // Starvation: both requesting continuously
    nxt(); clr_in(); tick();
    for (int i = 1; i <= 9; i++) begin
      nxt(); clr_in(); a_req = 1; b_req = 1; b_addr = 32'h300; tick();
      chk("starve_gnt", 32'(b_gnt), 32'(i == 9));
    end
    nxt(); clr_in(); a_req = 1; b_req = 1; tick();
    chk("starve_cleared", 32'(a_stall), 32'h0);

    // Address wrap
    nxt(); clr_in(); b_req = 1; b_addr = 32'hFFFF_FFFC; b_len = 1; tick();
    chk("wrap_beat0", m_addr, 32'hFFFF_FFFC);
    nxt(); clr_in(); tick();
    chk("wrap_beat1", m_addr, 32'h0);
    chk("wrap_done", 32'(b_done), 32'h1);

    // Reset in the middle of a 16-beat read
    nxt(); clr_in(); b_req = 1; b_len = 15; b_addr = 32'h200; tick();
    nxt(); clr_in(); tick();
    nxt(); clr_in(); tick();
    #1 rst = 0;
    #1;
    chk("rst_gnt", 32'(b_gnt), 32'h0);
    chk("rst_brv", 32'(b_rvalid), 32'h0);
    chk("rst_done", 32'(b_done), 32'h0);
    nxt(); tick();
    nxt(); rst = 1; tick();
    chk("rst_rel_gnt", 32'(b_gnt), 32'h0);
    nxt(); tick();
    chk("rst_rel_brv", 32'(b_rvalid), 32'h0);

    // Single-beat B read of data memory
    nxt(); clr_in(); b_req = 1; b_addr = 32'h40; tick();
    chk("sb_gnt", 32'(b_gnt), 32'h1);
    chk("sb_done", 32'(b_done), 32'h1);
    nxt(); clr_in(); tick();
    chk("sb_rvalid", 32'(b_rvalid), 32'h1);
    chk("sb_rdata", b_rdata, dm_rdata);
    chk("sb_idle", 32'(b_gnt), 32'h0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      nxt();
      rst = ($urandom_range(0, 79) != 0);
      a_req = 1'($urandom); a_we = 1'($urandom); a_sel = 1'($urandom);
      a_addr = $urandom & 32'hFFFF_FFFC; a_wdata = $urandom;
      b_req = ($urandom_range(0, 2) == 0);
      b_we = 1'($urandom); b_sel = 1'($urandom);
      b_addr = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0
                                            : ($urandom & 32'hFFFF_FFFC);
      b_len = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                          : 4'($urandom_range(0, 2));
      b_wdata = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32: data and address width.
REQ-002 Parameter STARVE, default 8: cycles B may wait before it takes priority over A.
REQ-003 clk  in  1: single clock, all state on rising edge.
REQ-004 rst  in  1: asynchronous, active-low reset.
REQ-005 a_req  in  1: CPU memory-stage access request, single word.
REQ-006 a_we  in  1: CPU write (1) or read (0).
REQ-007 a_sel  in  1: CPU target, 0 = data memory, 1 = pixel memory.
REQ-008 a_addr, a_wdata  in  N each: CPU byte address and write data.
REQ-009 a_stall  out  1: CPU access not served this cycle; pipeline must hold.
REQ-010 a_rvalid  out  1, a_rdata  out  N: CPU read data return.
REQ-011 b_req, b_we, b_sel  in  1 each: secondary (pixel engine) burst request, direction, target.
REQ-012 b_addr  in  N, b_len  in  4: burst start byte address and beat count minus 1 (1..16 beats).
REQ-013 b_wdata  in  N: burst write data, consumed on each b_gnt.
REQ-014 b_gnt  out  1: one B beat issued this cycle.
REQ-015 b_rvalid  out  1, b_rdata  out  N: B read data return.
REQ-016 b_done  out  1: pulses with the last beat of a B burst.
REQ-017 dm_we, pm_we  out  1 each: data / pixel memory write enables.
REQ-018 m_addr, m_wdata  out  N each: shared address and write data to both memories.
REQ-019 dm_rdata, pm_rdata  in  N each: memory read data, valid the cycle after the address (synchronous read).

Function
REQ-020 FSM states SHALL be IDLE and BURST; one access is issued per cycle at most.
REQ-021 IDLE, a_req=1, not (b_req=1 and starve_cnt==STARVE): A served this cycle, a_stall=0, state stays IDLE.
REQ-022 IDLE, b_req=1, and (a_req=0 or starve_cnt==STARVE): B beat 0 issued this cycle, b_addr/b_len/b_sel/b_we latched, b_gnt=1; next state BURST if b_len>0, else IDLE with b_done=1.
REQ-023 BURST: one B beat per cycle; address = previous +4, wrapping modulo 2^N; b_gnt=1 each beat; after beat b_len, b_done=1 the same cycle and state returns to IDLE.
REQ-024 A burst SHALL NOT be preempted, and changes to b_req or b_addr/b_len/b_sel/b_we during BURST SHALL be ignored.
REQ-025 a_stall = a_req and A not served this cycle, combinational.
REQ-026 starve_cnt: increments, saturating at STARVE, in each cycle b_req=1 and B is not granted; clears on any B grant and whenever b_req=0.
REQ-027 The served requester's address and write data SHALL be driven on m_addr/m_wdata; dm_we = served we and sel==0; pm_we = served we and sel==1.
REQ-028 With no access issued, dm_we=pm_we=0 and m_addr=m_wdata=0.
REQ-029 A read issued in cycle t SHALL produce the owner's rvalid=1 in t+1, with rdata taken from dm_rdata or pm_rdata per the registered sel.
REQ-030 Writes SHALL produce no rvalid.
REQ-031 rvalid of the other requester SHALL stay 0.
REQ-032 A and B SHALL never both be served in one cycle.

Reset
REQ-033 rst=0 SHALL force the following immediately, independent of clk: state IDLE, starve_cnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, b_done=0.
REQ-034 rst=0 SHALL force dm_we=pm_we=0, b_gnt=0 and a_stall=0.
REQ-035 Reset mid-burst SHALL abort the burst with no further beats and no b_done.
REQ-036 The first access SHALL be evaluated on the first rising edge after rst=1.

Verification
REQ-037 CPU read: a_req=1, a_sel=0, a_addr=0x10; dm_rdata=0xCAFE next cycle -> m_addr=0x10, a_stall=0; next cycle a_rvalid=1, a_rdata=0xCAFE.
REQ-038 Pixel write burst: b_req=1, b_we=1, b_sel=1, b_addr=0x100, b_len=3, a_req=0 -> pm_we=1 at 0x100,0x104,0x108,0x10C on 4 consecutive cycles, b_gnt=1 each, b_done on 4th; a_req raised on cycle 2 -> a_stall=1 until burst ends.
REQ-039 Starvation: a_req and b_req held high continuously -> A served 8 cycles; B granted on cycle 9; starve_cnt=0 afterward.
REQ-040 Address wrap: b_addr=0xFFFFFFFC, b_len=1 -> beats at 0xFFFFFFFC then 0x00000000.
REQ-041 Reset mid-burst: rst=0 during beat 2 of a 16-beat read -> outputs reset at once; no b_done, no b_rvalid after release.
REQ-042 Single-beat B read: b_len=0, b_sel=0 -> one b_gnt with b_done the same cycle; b_rvalid next cycle; state IDLE.
